// File: rtl/cam_frame_capture.sv
// Camera byte-stream to pixel-word capture with start/stop arming, frame decimation and cropping.
// Define CAPTURE_STATS_EN to add line-length error flag and per-frame line count.
module cam_frame_capture #(
   parameter int DATA_W    = 8,
   parameter int X_W       = 11,
   parameter int Y_W       = 10,
   parameter int CROP_X0   = 0,
   parameter int CROP_Y0   = 0,
   parameter int CROP_W    = 640,
   parameter int CROP_H    = 480,
   parameter int SKIP      = 0,
   parameter int MSB_FIRST = 1
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic [DATA_W-1:0]   iDATA,
   input  logic                iFVAL,
   input  logic                iLVAL,
   input  logic                iSTART,
   input  logic                iEND,
   output logic [2*DATA_W-1:0] oYCbCr,
   output logic                oDVAL,
   output logic [X_W-1:0]      oX_Cont,
   output logic [Y_W-1:0]      oY_Cont,
   output logic                oSOF,
   output logic                oEOF,
   output logic [31:0]         oFrame_Cont,
   output logic                oBUSY
`ifdef CAPTURE_STATS_EN
   ,
   output logic                oLINE_ERR,
   output logic [Y_W-1:0]      oLINES_LAST,
   input  logic                iCLR_STAT
`endif
);

   localparam int SK_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

   typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

   state_t state, state_nx;
   logic   stop_pend, stop_nx;
   logic   active;

   logic              fval_d, lv_d;
   logic              line_v, fs, fe, le;
   logic              phase;
   logic [DATA_W-1:0] first_byte;
   logic [X_W-1:0]    raw_x;
   logic [Y_W-1:0]    raw_y;
   logic [SK_W-1:0]   skip_cnt;
   logic              cap;
   logic              sof_pend;
   logic [32:0]       dx, dy;
   logic              x_in, y_in;
   logic              pair_done, dval_nx;
   logic [2*DATA_W-1:0] pixel;

   assign line_v = iFVAL & iLVAL;
   assign fs     = iFVAL & ~fval_d;
   assign fe     = ~iFVAL & fval_d;
   assign le     = lv_d & ~line_v;

   assign cap       = (skip_cnt == '0);
   assign pair_done = line_v & phase;
   assign pixel     = (MSB_FIRST != 0) ? {first_byte, iDATA} : {iDATA, first_byte};

   // Offsets carry a borrow bit so "below the window" is a sign test, not a compare against zero.
   assign dx   = {1'b0, 32'(raw_x)} - 33'(CROP_X0);
   assign dy   = {1'b0, 32'(raw_y)} - 33'(CROP_Y0);
   assign x_in = ~dx[32] && (dx[31:0] < 32'(CROP_W));
   assign y_in = ~dy[32] && (dy[31:0] < 32'(CROP_H));

   assign dval_nx = pair_done & active & cap & x_in & y_in;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state     <= IDLE;
         stop_pend <= 1'b0;
      end else begin
         state     <= state_nx;
         stop_pend <= (state == ACTIVE && state_nx == ACTIVE) ? stop_nx : 1'b0;
      end
   end

   always_comb begin
      state_nx = state;
      stop_nx  = iEND ? 1'b1 : (iSTART ? 1'b0 : stop_pend);
      case (state)
         IDLE:    if (iSTART && !iEND) state_nx = ARMED;
         ARMED:   if (iEND) state_nx = IDLE;
                  else if (fs) state_nx = ACTIVE;
         ACTIVE:  if (fe && stop_nx) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      active = (state == ACTIVE);
      oBUSY  = (state != IDLE);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         fval_d      <= 1'b0;
         lv_d        <= 1'b0;
         phase       <= 1'b0;
         first_byte  <= '0;
         raw_x       <= '0;
         raw_y       <= '0;
         skip_cnt    <= '0;
         sof_pend    <= 1'b0;
         oDVAL       <= 1'b0;
         oYCbCr      <= '0;
         oX_Cont     <= '0;
         oY_Cont     <= '0;
         oSOF        <= 1'b0;
         oEOF        <= 1'b0;
         oFrame_Cont <= '0;
      end else begin
         fval_d <= iFVAL;
         lv_d   <= line_v;

         if (line_v) begin
            phase <= ~phase;
            if (!phase) first_byte <= iDATA;
            else if (raw_x != '1) raw_x <= raw_x + 1'b1;
         end else begin
            phase <= 1'b0;
            raw_x <= '0;
         end

         if (fs) raw_y <= '0;
         else if (le && raw_y != '1) raw_y <= raw_y + 1'b1;

         if (fs && state == ARMED) skip_cnt <= '0;
         else if (fs && active) skip_cnt <= (skip_cnt == SK_W'(SKIP)) ? '0 : skip_cnt + 1'b1;

         oDVAL <= dval_nx;
         if (dval_nx) begin
            oYCbCr  <= pixel;
            oX_Cont <= dx[X_W-1:0];
            oY_Cont <= dy[Y_W-1:0];
         end

         oSOF <= dval_nx & sof_pend;
         if (fs) sof_pend <= 1'b1;
         else if (dval_nx) sof_pend <= 1'b0;

         oEOF <= fe & active & cap;
         if (fe && active && cap) oFrame_Cont <= oFrame_Cont + 1'b1;
      end
   end

`ifdef CAPTURE_STATS_EN
   localparam int unsigned EXP_BYTES = 2 * (CROP_X0 + CROP_W);

   logic [X_W+1:0] byte_cnt;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         byte_cnt    <= '0;
         oLINE_ERR   <= 1'b0;
         oLINES_LAST <= '0;
      end else begin
         if (line_v) begin
            if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
         end else begin
            byte_cnt <= '0;
         end

         if (iCLR_STAT) oLINE_ERR <= 1'b0;
         else if (le && active && cap && (32'(byte_cnt) != EXP_BYTES || byte_cnt[0]))
            oLINE_ERR <= 1'b1;

         // A line ending together with the frame has not reached raw_y yet.
         if (fe) oLINES_LAST <= (le && raw_y != '1) ? raw_y + 1'b1 : raw_y;
      end
   end
`endif

endmodule

// File: tb/tb_cam_frame_capture.sv
// Randomized bench for cam_frame_capture: three instances (plain, SKIP=2, offset crop LSB-first)
// share one byte stream and are checked against a frame-level reference model.
module tb_cam_frame_capture;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] data = '0;
   logic fval = 1'b0, lval = 1'b0, start = 1'b0, stop = 1'b0;

   logic [15:0] pix[N];
   logic        dval[N];
   logic [10:0] xc[N];
   logic [9:0]  yc[N];
   logic        sof[N], eof[N], busy[N];
   logic [31:0] fcnt[N];
`ifdef CAPTURE_STATS_EN
   logic        clr = 1'b0;
   logic        lerr[N];
   logic [9:0]  llast[N];
`endif

   always #5 clk = ~clk;

   cam_frame_capture #(.CROP_X0(0), .CROP_Y0(0), .CROP_W(4), .CROP_H(4), .SKIP(0), .MSB_FIRST(1)) dut_a (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iFVAL(fval), .iLVAL(lval), .iSTART(start), .iEND(stop),
      .oYCbCr(pix[0]), .oDVAL(dval[0]), .oX_Cont(xc[0]), .oY_Cont(yc[0]), .oSOF(sof[0]), .oEOF(eof[0]),
      .oFrame_Cont(fcnt[0]), .oBUSY(busy[0])
`ifdef CAPTURE_STATS_EN
      , .oLINE_ERR(lerr[0]), .oLINES_LAST(llast[0]), .iCLR_STAT(clr)
`endif
   );

   cam_frame_capture #(.CROP_X0(0), .CROP_Y0(0), .CROP_W(4), .CROP_H(4), .SKIP(2), .MSB_FIRST(1)) dut_b (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iFVAL(fval), .iLVAL(lval), .iSTART(start), .iEND(stop),
      .oYCbCr(pix[1]), .oDVAL(dval[1]), .oX_Cont(xc[1]), .oY_Cont(yc[1]), .oSOF(sof[1]), .oEOF(eof[1]),
      .oFrame_Cont(fcnt[1]), .oBUSY(busy[1])
`ifdef CAPTURE_STATS_EN
      , .oLINE_ERR(lerr[1]), .oLINES_LAST(llast[1]), .iCLR_STAT(clr)
`endif
   );

   cam_frame_capture #(.CROP_X0(2), .CROP_Y0(1), .CROP_W(2), .CROP_H(2), .SKIP(0), .MSB_FIRST(0)) dut_c (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iFVAL(fval), .iLVAL(lval), .iSTART(start), .iEND(stop),
      .oYCbCr(pix[2]), .oDVAL(dval[2]), .oX_Cont(xc[2]), .oY_Cont(yc[2]), .oSOF(sof[2]), .oEOF(eof[2]),
      .oFrame_Cont(fcnt[2]), .oBUSY(busy[2])
`ifdef CAPTURE_STATS_EN
      , .oLINE_ERR(lerr[2]), .oLINES_LAST(llast[2]), .iCLR_STAT(clr)
`endif
   );

   int cx0[N] = '{0, 0, 2};
   int cy0[N] = '{0, 0, 1};
   int cw[N]  = '{4, 4, 2};
   int ch[N]  = '{4, 4, 2};
   int skp[N] = '{0, 2, 0};
   bit msb[N] = '{1, 1, 0};

   typedef struct {
      logic [15:0] pix;
      int          x;
      int          y;
      bit          sof;
   } px_t;

   px_t exq[N][$];
   int  eofq[N][$];

   // Frame-level model: 0 idle, 1 waiting for a frame start, 2 capturing.
   int m_st = 0;
   bit m_stop = 0;
   int m_skip[N];
   bit m_cap[N];
   int m_frames[N];

   logic [7:0] fb[8][32];
   int flen[8];
   int fnl;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string pfx);
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s_dval%0d", pfx, k), dval[k], 0);
         check($sformatf("%s_pix%0d", pfx, k), pix[k], 0);
         check($sformatf("%s_x%0d", pfx, k), xc[k], 0);
         check($sformatf("%s_y%0d", pfx, k), yc[k], 0);
         check($sformatf("%s_sof%0d", pfx, k), sof[k], 0);
         check($sformatf("%s_eof%0d", pfx, k), eof[k], 0);
         check($sformatf("%s_frames%0d", pfx, k), fcnt[k], 0);
         check($sformatf("%s_busy%0d", pfx, k), busy[k], 0);
      end
   endtask

   task automatic pulse(input bit s, input bit e);
      if (e) begin
         if (m_st == 1) m_st = 0;
         else if (m_st == 2) m_stop = 1;
      end else if (s) begin
         if (m_st == 0) m_st = 1;
         else if (m_st == 2) m_stop = 0;
      end
      start = s;
      stop  = e;
      tick;
      start = 0;
      stop  = 0;
      tick;
   endtask

   task automatic build_rand(input int nl);
      fnl = nl;
      for (int y = 0; y < nl; y++) begin
         flen[y] = $urandom_range(4, 20);
         for (int b = 0; b < 32; b++) fb[y][b] = 8'($urandom);
      end
   endtask

   task automatic frame_start_model;
      logic [7:0] b0, b1;
      px_t e;
      bit first;
      if (m_st == 1) begin
         m_st = 2;
         m_stop = 0;
         for (int k = 0; k < N; k++) m_skip[k] = 0;
      end else if (m_st == 2) begin
         for (int k = 0; k < N; k++) m_skip[k] = (m_skip[k] + 1) % (skp[k] + 1);
      end
      for (int k = 0; k < N; k++) begin
         m_cap[k] = (m_st == 2) && (m_skip[k] == 0);
         if (!m_cap[k]) continue;
         first = 1;
         for (int y = 0; y < fnl; y++)
            for (int p = 0; p < flen[y] / 2; p++) begin
               b0 = fb[y][2*p];
               b1 = fb[y][2*p+1];
               if (p >= cx0[k] && p < cx0[k] + cw[k] && y >= cy0[k] && y < cy0[k] + ch[k]) begin
                  e.pix = msb[k] ? {b0, b1} : {b1, b0};
                  e.x = p - cx0[k];
                  e.y = y - cy0[k];
                  e.sof = first;
                  first = 0;
                  exq[k].push_back(e);
               end
            end
      end
   endtask

   // mid: 0 none, 1 start pulse, 2 end pulse, issued in the gap after line 0.
   task automatic run_frame(input int mid, input bit abort);
      frame_start_model();
      fval = 1;
      tick;
      tick;
      for (int y = 0; y < fnl; y++) begin
         for (int b = 0; b < flen[y]; b++) begin
            lval = 1;
            data = fb[y][b];
            tick;
         end
         if (abort && y == fnl - 1) begin
            #3 rst_n = 0;
            #1 check_zero("rst_mid");
            lval = 0;
            fval = 0;
            m_st = 0;
            m_stop = 0;
            for (int k = 0; k < N; k++) m_frames[k] = 0;
            tick;
            tick;
            rst_n = 1;
            tick;
            return;
         end
         lval = 0;
         data = 8'($urandom);
         tick;
         if (y == 0 && mid == 1) pulse(1, 0);
         else if (y == 0 && mid == 2) pulse(0, 1);
         else tick;
`ifdef CAPTURE_STATS_EN
         if (abort && y == 0) check("line_err_odd", lerr[0], 1);
`endif
      end
      tick;
      fval = 0;
      for (int k = 0; k < N; k++)
         if (m_st == 2 && m_cap[k]) begin
            m_frames[k]++;
            eofq[k].push_back(m_frames[k]);
         end
      if (m_st == 2 && m_stop) m_st = 0;
      repeat (4) tick;
      for (int k = 0; k < N; k++) check($sformatf("busy%0d", k), busy[k], m_st != 0);
   endtask

   always @(negedge clk) begin
      px_t e;
      int ef;
      for (int k = 0; k < N; k++) begin
         if (dval[k]) begin
            if (exq[k].size() == 0) check($sformatf("dval_extra%0d", k), dval[k], 0);
            else begin
               e = exq[k].pop_front();
               check($sformatf("pix%0d", k), pix[k], e.pix);
               check($sformatf("xc%0d", k), xc[k], e.x);
               check($sformatf("yc%0d", k), yc[k], e.y);
               check($sformatf("sof%0d", k), sof[k], e.sof);
            end
         end else if (sof[k]) begin
            check($sformatf("sof_stray%0d", k), sof[k], 0);
         end
         if (eof[k]) begin
            if (eofq[k].size() == 0) check($sformatf("eof_extra%0d", k), eof[k], 0);
            else begin
               ef = eofq[k].pop_front();
               check($sformatf("frames%0d", k), fcnt[k], ef);
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < N; k++) begin
         m_skip[k] = 0;
         m_cap[k] = 0;
         m_frames[k] = 0;
      end
      repeat (3) tick;
      check_zero("reset");
      rst_n = 1;
      tick;

      build_rand(3);
      run_frame(0, 0);

      pulse(1, 0);
      fnl = 4;
      for (int y = 0; y < 4; y++) begin
         flen[y] = 8;
         for (int b = 0; b < 32; b++) fb[y][b] = 8'(8'h10 + b);
      end
      run_frame(0, 0);
`ifdef CAPTURE_STATS_EN
      for (int k = 0; k < N; k++) begin
         check($sformatf("line_err_ok%0d", k), lerr[k], 0);
         check($sformatf("lines_last%0d", k), llast[k], 4);
      end
`endif

      fnl = 4;
      for (int y = 0; y < 4; y++) begin
         flen[y] = 16;
         for (int b = 0; b < 32; b++) fb[y][b] = 8'($urandom);
      end
      run_frame(0, 0);

      for (int i = 0; i < 6; i++) begin
         build_rand($urandom_range(2, 5));
         run_frame((i == 2) ? 1 : 0, 0);
      end

      build_rand(4);
      run_frame(2, 0);
      build_rand(3);
      run_frame(0, 0);
      build_rand(3);
      run_frame(1, 0);
      build_rand(5);
      run_frame(0, 0);
      pulse(1, 0);
      build_rand(4);
      run_frame(0, 0);
      pulse(0, 1);
      build_rand(4);
      run_frame(0, 0);

      pulse(1, 0);
      pulse(1, 1);
      for (int k = 0; k < N; k++) check($sformatf("busy_end_start%0d", k), busy[k], m_st != 0);
      build_rand(3);
      run_frame(0, 0);

      pulse(1, 0);
`ifdef CAPTURE_STATS_EN
      clr = 1;
      tick;
      clr = 0;
      tick;
      for (int k = 0; k < N; k++) check($sformatf("line_err_clr%0d", k), lerr[k], 0);
`endif
      fnl = 2;
      flen[0] = 7;
      flen[1] = 1;
      for (int y = 0; y < 2; y++)
         for (int b = 0; b < 32; b++) fb[y][b] = 8'($urandom);
      run_frame(0, 1);

      build_rand(3);
      run_frame(0, 0);
      pulse(1, 0);
      build_rand(4);
      run_frame(0, 0);

      repeat (4) tick;
      for (int k = 0; k < N; k++) begin
         check($sformatf("pix_left%0d", k), exq[k].size(), 0);
         check($sformatf("eof_left%0d", k), eofq[k].size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
